// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: A/D channel opcodes, the initiator FSM state
// encoding, and small opcode helpers used by the initiator.
package tl_pkg;

    localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET        = 3'd4;

    localparam logic [2:0] TL_D_ACK        = 3'd0;
    localparam logic [2:0] TL_D_ACKDATA    = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        A_SEND,
        D_WAIT,
        RSP
    } tl_mst_state_e;

    // A-channel opcode for a request; a write with every byte enabled is a full put.
    function automatic logic [2:0] tl_a_opcode(input logic we, input logic full_mask);
        logic [2:0] op;
        if (!we) begin
            op = TL_A_GET;
        end else if (full_mask) begin
            op = TL_A_PUTFULL;
        end else begin
            op = TL_A_PUTPARTIAL;
        end
        return op;
    endfunction

    function automatic logic [2:0] tl_d_expected(input logic [2:0] a_op);
        return (a_op == TL_A_GET) ? TL_D_ACKDATA : TL_D_ACK;
    endfunction

endpackage

// File: rtl/tl_ul_master.sv
// TileLink-UL initiator: turns a single-beat request/response port into one
// outstanding A-channel message and returns the matching D-channel reply.
module tl_ul_master
    import tl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_mask,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_size,
    output logic [SRC_W-1:0]    a_source,
    output logic [ADDR_W-1:0]   a_address,
    output logic [DATA_W/8-1:0] a_mask,
    output logic [DATA_W-1:0]   a_data,

    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SRC_W-1:0]    d_source,
    input  logic                d_denied,
    input  logic                d_corrupt,
    input  logic [DATA_W-1:0]   d_data
);

    localparam int               MASK_W   = DATA_W / 8;
    localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0]       BEAT_SZ  = 3'($clog2(MASK_W));
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam bit               TMO_EN   = (TIMEOUT != 0);

    tl_mst_state_e    state, state_n;
    logic [SRC_W-1:0] tag;
    logic [TMR_W-1:0] timer;

    logic req_fire;
    logic a_fire;
    logic d_match;
    logic tmo_hit;
    logic d_err;

    // a_source still holds the tag of the outstanding message, so it doubles
    // as the reference for filtering stale replies.
    assign d_match = (state == D_WAIT) && d_valid && (d_source == a_source);
    assign tmo_hit = TMO_EN && (state == D_WAIT) && (timer == TMR_LAST);
    assign d_err   = d_denied | d_corrupt | (d_opcode != tl_d_expected(a_opcode));

    always_comb begin
        state_n   = state;
        a_valid   = 1'b0;
        d_ready   = 1'b1;
        rsp_valid = 1'b0;
        req_fire  = 1'b0;
        a_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                req_fire = req_valid && req_ready;
                if (req_fire) begin
                    state_n = A_SEND;
                end
            end
            A_SEND: begin
                a_valid = 1'b1;
                d_ready = 1'b0;
                a_fire  = a_ready;
                if (a_fire) begin
                    state_n = D_WAIT;
                end
            end
            D_WAIT: begin
                if (d_match || tmo_hit) begin
                    state_n = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // req_ready is registered so it stays low while rst is held and rises on
    // the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
        end else begin
            state     <= state_n;
            req_ready <= (state_n == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag       <= '0;
            timer     <= '0;
            a_opcode  <= '0;
            a_size    <= '0;
            a_source  <= '0;
            a_address <= '0;
            a_mask    <= '0;
            a_data    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                a_opcode  <= tl_a_opcode(req_we, &req_mask);
                a_size    <= BEAT_SZ;
                a_source  <= tag;
                a_address <= req_addr;
                a_mask    <= req_we ? req_mask : {MASK_W{1'b1}};
                a_data    <= req_we ? req_wdata : '0;
            end
            if (a_fire) begin
                tag   <= tag + SRC_W'(1);
                timer <= '0;
            end
            if (state == D_WAIT) begin
                timer <= timer + TMR_W'(1);
            end
            // A matching beat takes priority over a timeout in the same cycle.
            if (d_match) begin
                rsp_err   <= d_err;
                rsp_rdata <= (!d_err && d_opcode == TL_D_ACKDATA) ? d_data : '0;
            end else if (tmo_hit) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tl_ul_master.sv
// Directed bench for tl_ul_master: a hand-driven responder on the D channel and
// a scoreboard of expected responses popped when rsp_valid is observed.
module tb_tl_ul_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int MASK_W  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [MASK_W-1:0] req_mask = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              a_valid;
    logic              a_ready = 1'b1;
    logic [2:0]        a_opcode;
    logic [2:0]        a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [MASK_W-1:0] a_mask;
    logic [DATA_W-1:0] a_data;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [2:0]        d_opcode = '0;
    logic [SRC_W-1:0]  d_source = '0;
    logic              d_denied = 1'b0;
    logic              d_corrupt = 1'b0;
    logic [DATA_W-1:0] d_data = '0;

    always #5 clk = ~clk;

    tl_ul_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SRC_W  (SRC_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_mask (req_mask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_size   (a_size),
        .a_source (a_source),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_source (d_source),
        .d_denied (d_denied),
        .d_corrupt(d_corrupt),
        .d_data   (d_data)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t             sb[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               t_req = 0;
    int               t_fire = 0;
    logic [SRC_W-1:0] exp_tag = '0;
    logic [SRC_W-1:0] cur_tag = '0;
    logic [SRC_W-1:0] old_tag = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_req(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                            input logic [7:0] m);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = m;
        t_req     = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_a(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] m,
                           input logic [63:0] d);
        chk("a_valid", 64'(a_valid), 64'(1'b1));
        chk("a_opcode", 64'(a_opcode), 64'(op));
        chk("a_size", 64'(a_size), 64'(3));
        chk("a_source", 64'(a_source), 64'(exp_tag));
        chk("a_address", 64'(a_address), 64'(addr));
        chk("a_mask", 64'(a_mask), 64'(m));
        chk("a_data", 64'(a_data), d);
        chk("d_ready_asend", 64'(d_ready), 64'(1'b0));
        chk("req_ready_busy", 64'(req_ready), 64'(1'b0));
    endtask

    task automatic a_go();
        a_ready = 1'b1;
        tick();
        cur_tag = exp_tag;
        exp_tag = exp_tag + 1'b1;
        t_fire  = cyc;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [SRC_W-1:0] src, input logic [63:0] d,
                          input logic den, input logic cor);
        d_valid   = 1'b1;
        d_opcode  = op;
        d_source  = src;
        d_data    = d;
        d_denied  = den;
        d_corrupt = cor;
        tick();
        d_valid   = 1'b0;
        d_denied  = 1'b0;
        d_corrupt = 1'b0;
    endtask

    task automatic d_reply(input logic [2:0] op, input logic [63:0] d, input logic den,
                           input logic cor, input logic [63:0] exp_rd, input logic exp_err);
        sb.push_back('{rdata: exp_rd, err: exp_err});
        d_beat(op, cur_tag, d, den, cor);
    endtask

    task automatic wait_rsp(input int t_ref, input int exp_lat);
        int   n = 0;
        rsp_t r;
        while (!rsp_valid && n < 64) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'(1'b1));
        if (exp_lat >= 0) begin
            chk("latency", 64'(cyc - t_ref), 64'(exp_lat));
        end
        chk("sb_has_entry", 64'(sb.size() != 0), 64'(1'b1));
        if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_valid_drop", 64'(rsp_valid), 64'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
        chk("rst_a_valid", 64'(a_valid), 64'(1'b0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(1'b0));
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_a_opcode", 64'(a_opcode), 64'(0));
        chk("rst_a_source", 64'(a_source), 64'(0));
        chk("rst_a_address", 64'(a_address), 64'(0));
        chk("rst_d_ready", 64'(d_ready), 64'(1'b1));
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'(1'b1));

        // Read with immediate A acceptance and a next-cycle AccessAckData
        send_req(1'b0, 32'h0000_1000, 64'hFFFF_0000_FFFF_0000, 8'h00);
        check_a(3'd4, 32'h0000_1000, 8'hFF, 64'h0);
        a_go();
        d_reply(3'd1, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 1'b0);
        wait_rsp(t_req, 3);

        // Full write then partial write, both acknowledged
        send_req(1'b1, 32'h0000_2008, 64'hA5A5_0101_5A5A_0202, 8'hFF);
        check_a(3'd0, 32'h0000_2008, 8'hFF, 64'hA5A5_0101_5A5A_0202);
        a_go();
        d_reply(3'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 64'h0, 1'b0);
        wait_rsp(t_req, 3);

        send_req(1'b1, 32'h0000_2010, 64'h0123_4567_89AB_CDEF, 8'h0F);
        check_a(3'd1, 32'h0000_2010, 8'h0F, 64'h0123_4567_89AB_CDEF);
        a_go();
        d_reply(3'd0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        wait_rsp(t_req, 3);

        // A-channel backpressure, then response backpressure
        a_ready = 1'b0;
        send_req(1'b0, 32'h0000_3000, 64'h0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            check_a(3'd4, 32'h0000_3000, 8'hFF, 64'h0);
            tick();
        end
        check_a(3'd4, 32'h0000_3000, 8'hFF, 64'h0);
        a_go();
        rsp_ready = 1'b0;
        d_reply(3'd1, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 64'(1'b1));
            chk("rsp_hold_rdata", rsp_rdata, 64'hCAFE_F00D_1234_5678);
            tick();
        end
        wait_rsp(t_req, -1);

        // Timeout with no reply, then a late reply during the next transaction
        send_req(1'b0, 32'h0000_4000, 64'h0, 8'h00);
        check_a(3'd4, 32'h0000_4000, 8'hFF, 64'h0);
        a_go();
        old_tag = cur_tag;
        sb.push_back('{rdata: 64'h0, err: 1'b1});
        wait_rsp(t_fire, TIMEOUT);

        send_req(1'b0, 32'h0000_4008, 64'h0, 8'h00);
        check_a(3'd4, 32'h0000_4008, 8'hFF, 64'h0);
        a_go();
        d_beat(3'd1, old_tag, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
        chk("stale_dropped", 64'(rsp_valid), 64'(1'b0));
        d_reply(3'd1, 64'h0F0E_0D0C_0B0A_0908, 1'b0, 1'b0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
        wait_rsp(t_req, -1);

        // Error replies: denied, wrong opcode for Get, wrong opcode for Put, corrupt
        send_req(1'b0, 32'h0000_5000, 64'h0, 8'h00);
        a_go();
        d_reply(3'd1, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 64'h0, 1'b1);
        wait_rsp(t_req, 3);

        send_req(1'b0, 32'h0000_5008, 64'h0, 8'h00);
        a_go();
        d_reply(3'd0, 64'h6666_6666_6666_6666, 1'b0, 1'b0, 64'h0, 1'b1);
        wait_rsp(t_req, 3);

        send_req(1'b1, 32'h0000_5010, 64'h7777, 8'hFF);
        a_go();
        d_reply(3'd1, 64'h8888_8888_8888_8888, 1'b0, 1'b0, 64'h0, 1'b1);
        wait_rsp(t_req, 3);

        send_req(1'b1, 32'h0000_5018, 64'h9999, 8'h03);
        a_go();
        d_reply(3'd0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1);
        wait_rsp(t_req, 3);

        // Reset while waiting for D; tag restarts at zero
        send_req(1'b0, 32'h0000_6000, 64'h0, 8'h00);
        a_go();
        rst = 1'b1;
        tick();
        chk("midrst_a_valid", 64'(a_valid), 64'(1'b0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("midrst_req_ready", 64'(req_ready), 64'(1'b0));
        chk("midrst_d_ready", 64'(d_ready), 64'(1'b1));
        rst = 1'b0;
        exp_tag = '0;
        tick();
        chk("after_rst_req_ready", 64'(req_ready), 64'(1'b1));
        send_req(1'b0, 32'h0000_6008, 64'h0, 8'h00);
        check_a(3'd4, 32'h0000_6008, 8'hFF, 64'h0);
        a_go();
        d_reply(3'd1, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0, 1'b0);
        wait_rsp(t_req, 3);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
